data_mem_access_unit: RTL and testbench



---
 rtl/data_mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_data_mem_access_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: turns core loads/stores into word-addressed memory
// requests with byte enables, and aligns/extends returned load data.
// One access is in flight at a time (req/gnt/rvalid handshake to memory).
// Optional feature macro: MISALIGNED_SPLIT_EN splits misaligned half/word
// accesses into two word beats; without it they are rejected with rsp_err.
module data_mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            mask_type,
  input  logic                  ext_type,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_mem_access_unit: DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, ext_q, err_q, split_q;
  logic [1:0]            mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, b0_q, b1_q;

  // Decode of the incoming request, used only at acceptance.
  logic accept, illegal_in, misal_in, err_in, split_in;
  assign accept     = (state_q == IDLE) && req_valid;
  assign illegal_in = (mask_type == 2'b11);
  assign misal_in   = ((mask_type == 2'b01) && (addr[1:0] == 2'b11)) ||
                      ((mask_type == 2'b10) && (addr[1:0] != 2'b00));
`ifdef MISALIGNED_SPLIT_EN
  assign err_in   = illegal_in;
  assign split_in = misal_in;
`else
  assign err_in   = illegal_in | misal_in;
  assign split_in = 1'b0;
`endif

  // Lane placement: an 8-bit enable / 64-bit data window over two words;
  // the low half is beat 0, the high half is beat 1 (only used when split).
  logic [1:0]            off;
  logic [7:0]            be_base, be_wide;
  logic [63:0]           wd_wide;
  logic [31:0]           ld_sh, ld_ext;
  logic [ADDR_WIDTH-1:0] base_addr;
  assign off       = addr_q[1:0];
  assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign be_base   = (mask_q == 2'b00) ? 8'h01 : (mask_q == 2'b01) ? 8'h03 : 8'h0F;
  assign be_wide   = be_base << off;
  assign wd_wide   = {32'b0, wdata_q} << {off, 3'b000};
  assign ld_sh     = 32'({b1_q, b0_q} >> {off, 3'b000});

  // Mask and extend the aligned load word; word loads ignore ext_type.
  always_comb begin
    ld_ext = ld_sh;
    case (mask_q)
      2'b00:   ld_ext = ext_q ? {24'b0, ld_sh[7:0]}  : {{24{ld_sh[7]}},  ld_sh[7:0]};
      2'b01:   ld_ext = ext_q ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the access sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = err_in ? RESP : REQ0;
      REQ0:  if (mem_gnt)   state_d = !we_q ? WAIT0 : (split_q ? REQ1 : RESP);
      WAIT0: if (mem_rvalid) state_d = split_q ? REQ1 : RESP;
      REQ1:  if (mem_gnt)   state_d = we_q ? RESP : WAIT1;
      WAIT1: if (mem_rvalid) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields captured at acceptance; read beats captured in WAIT states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0; ext_q <= 1'b0; err_q <= 1'b0; split_q <= 1'b0;
      mask_q <= 2'b00; addr_q <= '0; wdata_q <= '0; b0_q <= '0; b1_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        ext_q   <= ext_type;
        err_q   <= err_in;
        split_q <= split_in;
        mask_q  <= mask_type;
        addr_q  <= addr;
        wdata_q <= wdata;
        b0_q    <= '0;
        b1_q    <= '0;
      end
      if ((state_q == WAIT0) && mem_rvalid) b0_q <= mem_rdata;
      if ((state_q == WAIT1) && mem_rvalid) b1_q <= mem_rdata;
    end
  end

  // Outputs decode straight from state so reset drops them immediately.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? ld_ext : 32'b0;
    mem_req   = (state_q == REQ0) || (state_q == REQ1);
    mem_we    = mem_req & we_q;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'b0;
    if (state_q == REQ0) begin
      mem_addr  = base_addr;
      mem_be    = be_wide[3:0];
      mem_wdata = we_q ? wd_wide[31:0] : 32'b0;
    end else if (state_q == REQ1) begin
      mem_addr  = base_addr + ADDR_WIDTH'(4);
      mem_be    = be_wide[7:4];
      mem_wdata = we_q ? wd_wide[63:32] : 32'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_data_mem_access_unit;
  logic        clk = 1'b0, rst;
  logic        req_valid, req_ready, req_we, ext_type;
  logic [1:0]  mask_type;
  logic [31:0] addr, wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_err, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  int pass_cnt = 0, total_cnt = 0;

  data_mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .mask_type(mask_type), .ext_type(ext_type), .addr(addr),
    .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Aligned (non-split) load; called right after a falling edge.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] m,
                         input logic e, input logic [31:0] rd, input logic [3:0] be_exp,
                         input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; mask_type = m; ext_type = e; addr = a;
    nedge(); req_valid = 1'b0;
    chk({tag, "_req"},  {31'b0, mem_req}, 32'd1);
    chk({tag, "_be"},   {28'b0, mem_be}, {28'b0, be_exp});
    chk({tag, "_addr"}, mem_addr, a & ~32'h3);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0;
    chk({tag, "_wait"}, {31'b0, mem_req | rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    nedge(); mem_rvalid = 1'b0;
    chk({tag, "_vld"},  {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, exp);
    chk({tag, "_err"},  {31'b0, rsp_err}, 32'd0);
    nedge();
    chk({tag, "_done"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // Rejected access: response one cycle after acceptance, no memory request.
  task automatic do_err(input string tag, input logic we, input logic [1:0] m,
                        input logic [31:0] a);
    req_valid = 1'b1; req_we = we; mask_type = m; ext_type = 1'b0; addr = a;
    wdata = 32'hFFFF_FFFF;
    nedge(); req_valid = 1'b0;
    chk({tag, "_vld"},  {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_err"},  {31'b0, rsp_err}, 32'd1);
    chk({tag, "_req"},  {31'b0, mem_req}, 32'd0);
    chk({tag, "_data"}, rsp_rdata, 32'd0);
    nedge();
    chk({tag, "_done"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; mask_type = 2'b00; ext_type = 1'b0;
    addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_vld",   {31'b0, rsp_valid}, 32'd0);
    chk("rst_be",    {28'b0, mem_be}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    nedge(); rst = 1'b0;
    nedge();

    // Byte load, sign extend from lane 2.
    do_load("byte_ld", 32'h102, 2'b00, 1'b0, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
    // Halfword sign extend at offset 1 (allowed, not misaligned).
    do_load("half_ld_o1", 32'h41, 2'b01, 1'b0, 32'h00F0_0D00, 4'b0110, 32'hFFFF_F00D);
    // Halfword zero extend at offset 2.
    do_load("half_ld_zx", 32'h06, 2'b01, 1'b1, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF);
    // Word load ignores ext_type.
    do_load("word_ld", 32'h20, 2'b10, 1'b0, 32'h8000_1234, 4'b1111, 32'h8000_1234);

    // Half store with grant after two wait cycles.
    req_valid = 1'b1; req_we = 1'b1; mask_type = 2'b01; addr = 32'h202; wdata = 32'h1234_ABCD;
    nedge(); req_valid = 1'b0;
    chk("hst_req1",  {31'b0, mem_req}, 32'd1);
    chk("hst_we",    {31'b0, mem_we}, 32'd1);
    chk("hst_be",    {28'b0, mem_be}, 32'b1100);
    chk("hst_wdata", mem_wdata, 32'hABCD_0000);
    chk("hst_addr",  mem_addr, 32'h200);
    nedge();
    chk("hst_req2",  {31'b0, mem_req}, 32'd1);
    nedge();
    chk("hst_req3",  {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0;
    chk("hst_vld",   {31'b0, rsp_valid}, 32'd1);
    chk("hst_err",   {31'b0, rsp_err}, 32'd0);
    chk("hst_noreq", {31'b0, mem_req}, 32'd0);
    chk("hst_rdata", rsp_rdata, 32'd0);
    nedge();

    // Illegal mask type.
    do_err("illegal", 1'b0, 2'b11, 32'h100);

    // Misaligned accesses.
`ifdef MISALIGNED_SPLIT_EN
    req_valid = 1'b1; req_we = 1'b0; mask_type = 2'b10; ext_type = 1'b0; addr = 32'h301;
    nedge(); req_valid = 1'b0;
    chk("split_a0",  mem_addr, 32'h300);
    chk("split_be0", {28'b0, mem_be}, 32'b1110);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDDCC_BBAA;
    nedge(); mem_rvalid = 1'b0;
    chk("split_a1",  mem_addr, 32'h304);
    chk("split_be1", {28'b0, mem_be}, 32'b0001);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00EE;
    nedge(); mem_rvalid = 1'b0;
    chk("split_vld",  {31'b0, rsp_valid}, 32'd1);
    chk("split_data", rsp_rdata, 32'hEEDD_CCBB);
    chk("split_err",  {31'b0, rsp_err}, 32'd0);
    nedge();
`else
    do_err("misal_word", 1'b0, 2'b10, 32'h301);
    do_err("misal_half", 1'b1, 2'b01, 32'h7);
`endif

    // Reset while waiting for read data; a later rvalid is ignored.
    req_valid = 1'b1; req_we = 1'b0; mask_type = 2'b10; addr = 32'h10;
    nedge(); req_valid = 1'b0;
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0;
    rst = 1'b1; #1;
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_req",   {31'b0, mem_req}, 32'd0);
    nedge(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
    nedge(); mem_rvalid = 1'b0;
    chk("rstw_vld",   {31'b0, rsp_valid}, 32'd0);
    chk("rstw_ready2", {31'b0, req_ready}, 32'd1);
    nedge();
    chk("rstw_vld2",  {31'b0, rsp_valid}, 32'd0);

    // Reset while requesting drops mem_req at once.
    req_valid = 1'b1; req_we = 1'b1; mask_type = 2'b10; addr = 32'h20; wdata = 32'h5;
    nedge(); req_valid = 1'b0;
    chk("rstr_req1", {31'b0, mem_req}, 32'd1);
    rst = 1'b1; #1;
    chk("rstr_req0", {31'b0, mem_req}, 32'd0);
    chk("rstr_we0",  {31'b0, mem_we}, 32'd0);
    nedge(); rst = 1'b0;
    nedge();
    chk("rstr_vld",  {31'b0, rsp_valid}, 32'd0);

    // Request held high while busy: only accepted again after RESP.
    req_valid = 1'b1; req_we = 1'b1; mask_type = 2'b00; addr = 32'h3; wdata = 32'hAA;
    nedge();
    req_we = 1'b0; mask_type = 2'b10; ext_type = 1'b1; addr = 32'h20;
    chk("busy_ready", {31'b0, req_ready}, 32'd0);
    chk("busy_be",    {28'b0, mem_be}, 32'b1000);
    chk("busy_wdata", mem_wdata, 32'hAA00_0000);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0;
    chk("busy_resp",   {31'b0, rsp_valid}, 32'd1);
    chk("busy_ready2", {31'b0, req_ready}, 32'd0);
    nedge();
    chk("busy_idle",   {31'b0, req_ready}, 32'd1);
    nedge(); req_valid = 1'b0;
    chk("second_req",  {31'b0, mem_req}, 32'd1);
    chk("second_addr", mem_addr, 32'h20);
    chk("second_we",   {31'b0, mem_we}, 32'd0);
    mem_gnt = 1'b1;
    nedge(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8000_1234;
    nedge(); mem_rvalid = 1'b0;
    chk("second_data", rsp_rdata, 32'h8000_1234);
    nedge();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
